// File: rtl/cpu_pio_pkg.sv
// Shared constants for the CPU-side PIO blocks (control and status PIOs).
package cpu_pio_pkg;

  typedef logic [1:0] pio_addr_t;

  localparam pio_addr_t PIO_ADDR_DATA = 2'd0;
  localparam pio_addr_t PIO_ADDR_DIR  = 2'd1;
  localparam pio_addr_t PIO_ADDR_MASK = 2'd2;
  localparam pio_addr_t PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/cpu_pio_edge_detect.sv
// Input sampling chain, previous-value register and per-bit edge select.
// Optional macro CPU_STATUS_PIO_SYNC_EN inserts a two-flop synchronizer on in_port.
module cpu_pio_edge_detect #(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_hit
);
  import cpu_pio_pkg::*;

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

`ifdef CPU_STATUS_PIO_SYNC_EN
  // data_in doubles as the second synchronizer stage, so the build adds exactly one cycle
  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      data_in <= '0;
    end else begin
      s1      <= in_port;
      data_in <= s1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_in <= '0;
    end else begin
      data_in <= in_port;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= data_in;
    end
  end

  always_comb begin
    rise = data_in & ~prev;
    fall = ~data_in & prev;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_hit = fall;
      EDGE_ANY:     edge_hit = rise | fall;
      default:      edge_hit = rise;
    endcase
  end

endmodule

// File: rtl/cpu_status_pio.sv
// Avalon-MM input PIO: sampled status bus, edge-capture register and maskable irq.
// Optional macro CPU_STATUS_PIO_SYNC_EN adds a two-flop input synchronizer (+1 cycle latency).
module cpu_status_pio #(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  import cpu_pio_pkg::*;

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_next;
  logic             irq_next;
  logic             wr;

  cpu_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_detect (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data_in  (data_in),
    .edge_hit (edge_hit)
  );

  assign wr = chipselect & ~write_n;

  // A new edge always wins over a same-cycle write-1-to-clear so no event is dropped
  always_comb begin
    mask_next  = mask;
    clear_bits = '0;
    if (wr && address == PIO_ADDR_MASK) begin
      mask_next = writedata[WIDTH-1:0];
    end
    if (wr && address == PIO_ADDR_EDGE) begin
      clear_bits = writedata[WIDTH-1:0];
    end
    edge_capture_next = edge_hit | (edge_capture & ~clear_bits);
  end

  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA: rd_next[WIDTH-1:0] = data_in;
      PIO_ADDR_MASK: rd_next[WIDTH-1:0] = mask;
      PIO_ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      default:       rd_next = '0;
    endcase
  end

  always_comb begin
    if (IRQ_TYPE == IRQ_LEVEL) begin
      irq_next = |(data_in & mask);
    end else begin
      irq_next = |(edge_capture_next & mask_next);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask         <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      mask         <= mask_next;
      edge_capture <= edge_capture_next;
      readdata     <= rd_next;
      irq          <= irq_next;
    end
  end

endmodule
